// File: rtl/mmio_bus_router_if.sv
// CPU data-port, block-memory and MMIO-channel signals of the bus router,
// grouped so that the router and its environment share one connection.
interface mmio_bus_router_if #(
  parameter int NUM_CH       = 4,
  parameter int CH_SPAN_LOG2 = 3
);
  // CPU data port
  logic [31:0]            cpu_addr;
  logic [31:0]            cpu_din;
  logic                   cpu_wea;
  logic                   cpu_rea;
  logic [3:0]             cpu_wen;
  logic [31:0]            cpu_dout;
  logic                   cpu_hold;
  logic                   cpu_err;
  // Block memory
  logic                   mem_en;
  logic [3:0]             mem_wen;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_din;
  logic [31:0]            mem_dout;
  // MMIO channels
  logic [NUM_CH-1:0]      ch_sel;
  logic                   ch_wen;
  logic                   ch_ren;
  logic [CH_SPAN_LOG2-1:0] ch_addr;
  logic [31:0]            ch_din;
  logic [NUM_CH*32-1:0]   ch_dout;
  logic [NUM_CH-1:0]      ch_ack;

  // Router side
  modport slave (
    input  cpu_addr, cpu_din, cpu_wea, cpu_rea, cpu_wen,
    input  mem_dout, ch_dout, ch_ack,
    output cpu_dout, cpu_hold, cpu_err,
    output mem_en, mem_wen, mem_addr, mem_din,
    output ch_sel, ch_wen, ch_ren, ch_addr, ch_din
  );

  // CPU / memory / peripheral side
  modport master (
    output cpu_addr, cpu_din, cpu_wea, cpu_rea, cpu_wen,
    output mem_dout, ch_dout, ch_ack,
    input  cpu_dout, cpu_hold, cpu_err,
    input  mem_en, mem_wen, mem_addr, mem_din,
    input  ch_sel, ch_wen, ch_ren, ch_addr, ch_din
  );
endinterface

// File: rtl/mmio_bus_router.sv
// MMIO bus router: decodes each CPU data-port access into block memory,
// one of NUM_CH MMIO channels, or unmapped space. Channel accesses stall the
// CPU until the channel acks or a bounded timeout expires; read data returns
// through a registered select so a back-to-back access cannot corrupt it.
module mmio_bus_router #(
  parameter int          NUM_CH       = 4,
  parameter logic [19:0] MMIO_BASE    = 20'haaaaa,
  parameter logic [11:0] CH_BASE      = 12'h400,
  parameter int          CH_SPAN_LOG2 = 3,
  parameter int          MEM_LAT      = 1,
  parameter int          TIMEOUT      = 15
) (
  input  logic             clk,
  input  logic             Rst,
  mmio_bus_router_if.slave bus_io
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_CH_WAIT  = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // Where cpu_dout comes from this cycle: the held register or live memory data
  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic              rd_q, rd_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;

  logic              req_s, load_s, store_s;
  logic              is_mem_s, is_ch_s;
  logic [11:0]       rel_s, win_s;
  logic [NUM_CH-1:0] dec_sel_s;
  logic              ack_now_s, ack_wait_s;
  logic [31:0]       cpu_dout_s;

  logic                    mem_en_s, ch_wen_s, ch_ren_s, hold_s;
  logic [3:0]              mem_wen_s;
  logic [NUM_CH-1:0]       ch_sel_s;
  logic [CH_SPAN_LOG2-1:0] ch_addr_s;

  // OR together the read-data slices of the selected channel(s)
  function automatic logic [31:0] pick_data(input logic [NUM_CH-1:0]    sel,
                                            input logic [NUM_CH*32-1:0] data);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel[k]) begin
        r = r | data[32*k +: 32];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Request qualification and address decode
  always_comb begin
    req_s    = bus_io.cpu_wea | bus_io.cpu_rea;
    store_s  = bus_io.cpu_wea;
    load_s   = bus_io.cpu_rea & ~bus_io.cpu_wea;
    is_mem_s = (bus_io.cpu_addr[31:17] == 15'd0);
    rel_s    = bus_io.cpu_addr[11:0] - CH_BASE;
    win_s    = rel_s >> CH_SPAN_LOG2;
    is_ch_s  = (bus_io.cpu_addr[31:12] == MMIO_BASE) &&
               (bus_io.cpu_addr[11:0] >= CH_BASE) &&
               (win_s < 12'(NUM_CH));
    dec_sel_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (is_ch_s && (win_s == 12'(k))) begin
        dec_sel_s[k] = 1'b1;
      end else begin
        dec_sel_s[k] = 1'b0;
      end
    end
    ack_now_s  = |(bus_io.ch_ack & dec_sel_s);
    ack_wait_s = |(bus_io.ch_ack & sel_q);
  end

  // Live memory data is shown only in the cycle the registered select points at it
  always_comb begin
    if (src_q == SRC_MEM) begin
      cpu_dout_s = bus_io.mem_dout;
    end else begin
      cpu_dout_s = dout_q;
    end
  end

  // Next-state, strobes and stall generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    dout_d    = cpu_dout_s;
    src_d     = SRC_REG;
    err_d     = 1'b0;
    mem_en_s  = 1'b0;
    mem_wen_s = 4'd0;
    ch_sel_s  = {NUM_CH{1'b0}};
    ch_wen_s  = 1'b0;
    ch_ren_s  = 1'b0;
    ch_addr_s = {CH_SPAN_LOG2{1'b0}};
    hold_s    = 1'b0;
    if (Rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          state_d = ST_IDLE;
          if (req_s) begin
            if (is_mem_s) begin
              mem_en_s  = 1'b1;
              mem_wen_s = store_s ? bus_io.cpu_wen : 4'd0;
              rd_d      = load_s;
              if (MEM_LAT > 1) begin
                hold_s  = 1'b1;
                cnt_d   = 8'd0;
                state_d = ST_MEM_WAIT;
              end else begin
                src_d = load_s ? SRC_MEM : SRC_REG;
              end
            end else if (is_ch_s) begin
              ch_sel_s  = dec_sel_s;
              ch_wen_s  = store_s;
              ch_ren_s  = load_s;
              ch_addr_s = rel_s[CH_SPAN_LOG2-1:0];
              if (ack_now_s) begin
                // Same-cycle ack completes without a stall
                state_d = ST_RESP;
                dout_d  = load_s ? pick_data(dec_sel_s, bus_io.ch_dout) : 32'd0;
              end else begin
                hold_s  = 1'b1;
                sel_d   = dec_sel_s;
                rd_d    = load_s;
                cnt_d   = 8'd0;
                state_d = ST_CH_WAIT;
              end
            end else begin
              // Unmapped: error response next cycle, nothing touched
              state_d = ST_RESP;
              dout_d  = 32'd0;
              err_d   = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          // Stall drops one cycle before the memory data is presented
          if (cnt_q == 8'(MEM_LAT - 2)) begin
            state_d = ST_IDLE;
            src_d   = rd_q ? SRC_MEM : SRC_REG;
          end else begin
            hold_s = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end
        end
        ST_CH_WAIT: begin
          hold_s   = 1'b1;
          ch_sel_s = sel_q;
          if (ack_wait_s) begin
            // An ack on the timeout cycle still counts as a good completion
            state_d = ST_RESP;
            sel_d   = {NUM_CH{1'b0}};
            dout_d  = rd_q ? pick_data(sel_q, bus_io.ch_dout) : 32'd0;
          end else if ((cnt_q + 8'd1) == 8'(TIMEOUT)) begin
            state_d = ST_RESP;
            sel_d   = {NUM_CH{1'b0}};
            dout_d  = 32'd0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_REG;
      cnt_q   <= 8'd0;
      sel_q   <= {NUM_CH{1'b0}};
      rd_q    <= 1'b0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.cpu_dout = cpu_dout_s;
  assign bus_io.cpu_err  = err_q;
  assign bus_io.cpu_hold = hold_s;
  assign bus_io.mem_en   = mem_en_s;
  assign bus_io.mem_wen  = mem_wen_s;
  assign bus_io.mem_addr = bus_io.cpu_addr;
  assign bus_io.mem_din  = bus_io.cpu_din;
  assign bus_io.ch_sel   = ch_sel_s;
  assign bus_io.ch_wen   = ch_wen_s;
  assign bus_io.ch_ren   = ch_ren_s;
  assign bus_io.ch_addr  = ch_addr_s;
  assign bus_io.ch_din   = bus_io.cpu_din;

endmodule

// File: tb/tb_mmio_bus_router.sv
// Directed bench for mmio_bus_router: a table of single-cycle accesses with
// hand-computed results, plus sequences for stalls, timeout, and reset.
module tb_mmio_bus_router;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mmio_bus_router_if #(.NUM_CH(4), .CH_SPAN_LOG2(3)) bus ();

  mmio_bus_router dut (
    .clk    (clk),
    .Rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wea;
    logic        rea;
    logic [3:0]  wen;
    logic [3:0]  ack;
    logic [31:0] mdout_next;
    logic        e_men;
    logic [3:0]  e_mwen;
    logic [3:0]  e_sel;
    logic        e_wen;
    logic        e_ren;
    logic [2:0]  e_caddr;
    logic        e_hold;
    logic [31:0] e_dout;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic we, input logic re,
                              input logic [3:0] wn, input logic [3:0] ak,
                              input logic [31:0] mn, input logic em,
                              input logic [3:0] emw, input logic [3:0] es,
                              input logic ew, input logic er, input logic [2:0] eca,
                              input logic eh, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.addr = a; v.wea = we; v.rea = re; v.wen = wn; v.ack = ak; v.mdout_next = mn;
    v.e_men = em; v.e_mwen = emw; v.e_sel = es; v.e_wen = ew; v.e_ren = er;
    v.e_caddr = eca; v.e_hold = eh; v.e_dout = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic re, input logic [3:0] wn);
    bus.cpu_addr = a;
    bus.cpu_din  = 32'hC0FF_EE00 ^ a;
    bus.cpu_wea  = we;
    bus.cpu_rea  = re;
    bus.cpu_wen  = wn;
  endtask

  task automatic idle_bus();
    bus.cpu_wea = 1'b0;
    bus.cpu_rea = 1'b0;
    bus.cpu_wen = 4'd0;
    bus.ch_ack  = 4'd0;
  endtask

  vec_t vecs[13];
  int   nh;
  int   selbad;
  bit   done;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cpu_addr = 32'd0;
    bus.cpu_din  = 32'd0;
    bus.cpu_wea  = 1'b0;
    bus.cpu_rea  = 1'b0;
    bus.cpu_wen  = 4'd0;
    bus.mem_dout = 32'd0;
    bus.ch_ack   = 4'd0;
    bus.ch_dout  = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

    //              addr          we    re    wen      ack      mem_dout@T+1   men   mwen     sel      cw    cr    ca    hold  dout@T+1       err
    vecs[0]  = mk(32'h0001_0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    vecs[1]  = mk(32'h0000_0100, 1'b1, 1'b0, 4'b0101, 4'b0000, 32'h1234_5678, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mk(32'h0001_FFFC, 1'b1, 1'b1, 4'b1111, 4'b0000, 32'hAAAA_5555, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    vecs[3]  = mk(32'hAAAA_A408, 1'b0, 1'b1, 4'b0000, 4'b0010, 32'h0000_0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, 3'd0, 1'b0, 32'h2222_0001, 1'b0);
    vecs[4]  = mk(32'hAAAA_A40A, 1'b1, 1'b0, 4'b1111, 4'b0010, 32'h0000_0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0000, 1'b0);
    vecs[5]  = mk(32'hAAAA_A41F, 1'b0, 1'b1, 4'b0000, 4'b1000, 32'h0000_0000, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1, 3'd7, 1'b0, 32'h4444_0003, 1'b0);
    vecs[6]  = mk(32'h0000_0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0BAD_F00D, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0BAD_F00D, 1'b0);
    vecs[7]  = mk(32'hAAAA_A404, 1'b1, 1'b1, 4'b0011, 4'b0001, 32'h0000_0000, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0000_0000, 1'b0);
    vecs[8]  = mk(32'h0000_0200, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h7777_8888, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'h7777_8888, 1'b0);
    vecs[9]  = mk(32'hAAAA_A420, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1);
    vecs[10] = mk(32'hAAAA_A3FC, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1);
    vecs[11] = mk(32'h0002_0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1);
    vecs[12] = mk(32'hAAAA_B404, 1'b0, 1'b1, 4'b0000, 4'b0001, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1);

    // Reset with a channel request pending; everything must come up idle
    drive(32'hAAAA_A404, 1'b0, 1'b1, 4'd0);
    repeat (3) tick();
    rst = 1'b0;
    idle_bus();
    @(negedge clk);
    check("rst_dout", bus.cpu_dout, 32'd0);
    check("rst_err",  bus.cpu_err,  32'd0);
    check("rst_hold", bus.cpu_hold, 32'd0);
    check("rst_sel",  bus.ch_sel,   32'd0);
    check("rst_men",  bus.mem_en,   32'd0);
    check("rst_ren",  bus.ch_ren,   32'd0);

    // Table: one-cycle accesses, strobes at T, response at T+1
    for (int i = 0; i < 13; i++) begin
      tick();
      drive(vecs[i].addr, vecs[i].wea, vecs[i].rea, vecs[i].wen);
      bus.ch_ack   = vecs[i].ack;
      bus.mem_dout = 32'd0;
      @(negedge clk);
      check($sformatf("v%0d_men", i),   bus.mem_en,   {31'd0, vecs[i].e_men});
      check($sformatf("v%0d_mwen", i),  bus.mem_wen,  {28'd0, vecs[i].e_mwen});
      check($sformatf("v%0d_sel", i),   bus.ch_sel,   {28'd0, vecs[i].e_sel});
      check($sformatf("v%0d_cwen", i),  bus.ch_wen,   {31'd0, vecs[i].e_wen});
      check($sformatf("v%0d_cren", i),  bus.ch_ren,   {31'd0, vecs[i].e_ren});
      check($sformatf("v%0d_caddr", i), bus.ch_addr,  {29'd0, vecs[i].e_caddr});
      check($sformatf("v%0d_hold", i),  bus.cpu_hold, {31'd0, vecs[i].e_hold});
      check($sformatf("v%0d_err0", i),  bus.cpu_err,  32'd0);
      tick();
      idle_bus();
      bus.mem_dout = vecs[i].mdout_next;
      @(negedge clk);
      check($sformatf("v%0d_dout", i),  bus.cpu_dout, vecs[i].e_dout);
      check($sformatf("v%0d_err", i),   bus.cpu_err,  {31'd0, vecs[i].e_err});
      check($sformatf("v%0d_hold1", i), bus.cpu_hold, 32'd0);
    end

    // Channel 0 load acked at T+3; a stray ack on channel 1 at T+2 is ignored
    tick();
    bus.ch_dout[31:0] = 32'h0000_0003;
    drive(32'hAAAA_A404, 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    check("ch0_T_sel",   bus.ch_sel,   32'h1);
    check("ch0_T_ren",   bus.ch_ren,   32'h1);
    check("ch0_T_caddr", bus.ch_addr,  32'h4);
    check("ch0_T_hold",  bus.cpu_hold, 32'h1);
    tick();
    @(negedge clk);
    check("ch0_T1_sel",  bus.ch_sel,   32'h1);
    check("ch0_T1_ren",  bus.ch_ren,   32'h0);
    check("ch0_T1_hold", bus.cpu_hold, 32'h1);
    tick();
    bus.ch_ack = 4'b0010;
    @(negedge clk);
    check("ch0_T2_hold", bus.cpu_hold, 32'h1);
    tick();
    bus.ch_ack = 4'b0001;
    @(negedge clk);
    check("ch0_T3_sel",  bus.ch_sel,   32'h1);
    check("ch0_T3_hold", bus.cpu_hold, 32'h1);
    tick();
    idle_bus();
    @(negedge clk);
    check("ch0_T4_dout", bus.cpu_dout, 32'h0000_0003);
    check("ch0_T4_err",  bus.cpu_err,  32'h0);
    check("ch0_T4_hold", bus.cpu_hold, 32'h0);
    check("ch0_T4_sel",  bus.ch_sel,   32'h0);
    tick();
    @(negedge clk);
    check("ch0_T5_dout", bus.cpu_dout, 32'h0000_0003);

    // Channel 2 load with no ack: 16 stalled cycles, then one error cycle
    tick();
    drive(32'hAAAA_A410, 1'b0, 1'b1, 4'd0);
    nh = 0;
    selbad = 0;
    done = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      if (j > 0) begin
        tick();
        if (bus.cpu_err === 1'b1) begin
          done = 1'b1;
          idle_bus();
        end
      end
      if (!done) begin
        @(negedge clk);
        if (bus.cpu_hold === 1'b1) nh++;
        if (bus.ch_sel !== 4'b0100) selbad++;
      end
    end
    idle_bus();
    check("to_reached", {31'd0, done}, 32'h1);
    check("to_hold_cycles", nh, 32'd16);
    check("to_sel_held", selbad, 32'd0);
    @(negedge clk);
    check("to_err",  bus.cpu_err,  32'h1);
    check("to_dout", bus.cpu_dout, 32'h0);
    check("to_sel",  bus.ch_sel,   32'h0);
    check("to_hold", bus.cpu_hold, 32'h0);
    tick();
    @(negedge clk);
    check("to_err_clr", bus.cpu_err, 32'h0);

    // Ack arriving on the cycle the count reaches TIMEOUT wins
    tick();
    drive(32'hAAAA_A410, 1'b0, 1'b1, 4'd0);
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (j == 15) bus.ch_ack = 4'b0100;
    end
    @(negedge clk);
    check("race_hold", bus.cpu_hold, 32'h1);
    tick();
    idle_bus();
    @(negedge clk);
    check("race_err",  bus.cpu_err,  32'h0);
    check("race_dout", bus.cpu_dout, 32'h3333_0002);

    // Back-to-back memory loads: each cycle's data comes from its own access
    tick();
    drive(32'h0000_0040, 1'b0, 1'b1, 4'd0);
    bus.mem_dout = 32'd0;
    @(negedge clk);
    check("b2b_men0", bus.mem_en, 32'h1);
    tick();
    drive(32'h0001_0044, 1'b0, 1'b1, 4'd0);
    bus.mem_dout = 32'h600D_0001;
    @(negedge clk);
    check("b2b_dout1", bus.cpu_dout, 32'h600D_0001);
    check("b2b_men1",  bus.mem_en,   32'h1);
    check("b2b_hold1", bus.cpu_hold, 32'h0);
    tick();
    idle_bus();
    bus.mem_dout = 32'h600D_0002;
    @(negedge clk);
    check("b2b_dout2", bus.cpu_dout, 32'h600D_0002);
    tick();
    bus.mem_dout = 32'hFFFF_FFFF;
    @(negedge clk);
    check("b2b_keep", bus.cpu_dout, 32'h600D_0002);

    // Reset during a channel wait, then a late ack that must be dropped
    tick();
    drive(32'hAAAA_A400, 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    check("rw_hold", bus.cpu_hold, 32'h1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_bus();
    bus.ch_ack = 4'b0001;
    @(negedge clk);
    check("rw_hold0", bus.cpu_hold, 32'h0);
    check("rw_sel0",  bus.ch_sel,   32'h0);
    check("rw_err0",  bus.cpu_err,  32'h0);
    check("rw_dout0", bus.cpu_dout, 32'h0);
    tick();
    bus.ch_ack = 4'd0;
    @(negedge clk);
    check("rw_late_err",  bus.cpu_err,  32'h0);
    check("rw_late_dout", bus.cpu_dout, 32'h0);
    tick();
    drive(32'h0001_0010, 1'b0, 1'b1, 4'd0);
    bus.mem_dout = 32'd0;
    @(negedge clk);
    check("rw_new_men",  bus.mem_en,   32'h1);
    check("rw_new_hold", bus.cpu_hold, 32'h0);
    tick();
    idle_bus();
    bus.mem_dout = 32'h5A5A_A5A5;
    @(negedge clk);
    check("rw_new_dout", bus.cpu_dout, 32'h5A5A_A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
